// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: funct codes, FSM states, op kinds.
package muldiv_pkg;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    typedef enum logic [1:0] {MUL_S, MUL_U, DIV_S, DIV_U} op_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiplier / restoring divider with sign fix-up.
// The divider is only built when MULDIV_DIV_EN is defined.
module muldiv_datapath
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start_i,
    input  logic        step_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o,
    output logic        div_zero_o
);

    op_t         op_q;
    logic        neg_res_q;
    logic [63:0] acc_q, acc_d;   // product, or remainder in [31:0]
    logic [63:0] mc_q, mc_d;     // shifted multiplicand, or divisor in [31:0]
    logic [31:0] mq_q, mq_d;     // multiplier, or dividend shifting into quotient
    logic        signed_op;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod;

    assign signed_op = (op_t'(op_i) == MUL_S) || (op_t'(op_i) == DIV_S);
    assign a_mag     = (signed_op && a_i[31]) ? (~a_i + 32'd1) : a_i;
    assign b_mag     = (signed_op && b_i[31]) ? (~b_i + 32'd1) : b_i;

`ifdef MULDIV_DIV_EN
    logic        is_div_q;
    logic        neg_rem_q;
    logic        b_zero_q;
    logic [31:0] a_orig_q;
    logic [32:0] rem_sh;
    logic [33:0] diff;

    assign is_div_q = (op_q == DIV_S) || (op_q == DIV_U);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            a_orig_q  <= '0;
        end else if (clk_en && start_i) begin
            neg_rem_q <= (op_t'(op_i) == DIV_S) && a_i[31];
            b_zero_q  <= (b_i == 32'd0);
            a_orig_q  <= a_i;
        end
    end
`endif

    always_comb begin
        acc_d = acc_q;
        mc_d  = mc_q;
        mq_d  = mq_q;
`ifdef MULDIV_DIV_EN
        rem_sh = {acc_q[31:0], mq_q[31]};
        diff   = {1'b0, rem_sh} - {2'b00, mc_q[31:0]};
        if (is_div_q) begin
            if (!diff[33]) begin
                acc_d = {32'd0, diff[31:0]};
                mq_d  = {mq_q[30:0], 1'b1};
            end else begin
                acc_d = {32'd0, rem_sh[31:0]};
                mq_d  = {mq_q[30:0], 1'b0};
            end
        end else
`endif
        begin
            if (mq_q[0]) begin
                acc_d = acc_q + mc_q;
            end
            mc_d = {mc_q[62:0], 1'b0};
            mq_d = {1'b0, mq_q[31:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= MUL_S;
            neg_res_q <= 1'b0;
            acc_q     <= '0;
            mc_q      <= '0;
            mq_q      <= '0;
        end else if (clk_en) begin
            if (start_i) begin
                op_q      <= op_t'(op_i);
                neg_res_q <= signed_op && (a_i[31] ^ b_i[31]);
                acc_q     <= '0;
                mc_q      <= {32'd0, b_mag};
                mq_q      <= a_mag;
            end else if (step_i) begin
                acc_q <= acc_d;
                mc_q  <= mc_d;
                mq_q  <= mq_d;
            end
        end
    end

    assign prod = neg_res_q ? (~acc_q + 64'd1) : acc_q;

    always_comb begin
        res_hi_o   = prod[63:32];
        res_lo_o   = prod[31:0];
        div_zero_o = 1'b0;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
            div_zero_o = b_zero_q;
            if (b_zero_q) begin
                res_lo_o = 32'hFFFF_FFFF;
                res_hi_o = a_orig_q;
            end else begin
                res_lo_o = neg_res_q ? (~mq_q + 32'd1) : mq_q;
                res_hi_o = neg_rem_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
            end
        end
`endif
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/DIV unit with HI/LO and pipeline stall request.
// Optional divider enabled by defining MULDIV_DIV_EN.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    input  logic            ex_md_valid,
    input  logic [5:0]      ex_function_code,
    input  logic [XLEN-1:0] ex_dato_1,
    input  logic [XLEN-1:0] ex_dato_2,
    output logic            md_stall,
    output logic [XLEN-1:0] md_mf_result,
    output logic [XLEN-1:0] md_hi,
    output logic [XLEN-1:0] md_lo,
    output logic            md_div_by_zero
);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        is_mul, is_div, start, step;
    logic [1:0]  op_sel;
    logic [31:0] res_hi, res_lo;
    logic        dp_div_zero;

    assign is_mul = ex_md_valid && (ex_function_code == F_MULT || ex_function_code == F_MULTU);
`ifdef MULDIV_DIV_EN
    assign is_div = ex_md_valid && (ex_function_code == F_DIV || ex_function_code == F_DIVU);
`else
    assign is_div = 1'b0;
`endif

    always_comb begin
        case (ex_function_code)
            F_MULT:  op_sel = MUL_S;
            F_MULTU: op_sel = MUL_U;
            F_DIV:   op_sel = DIV_S;
            default: op_sel = DIV_U;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        md_stall = 1'b0;
        start    = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mul || is_div) begin
                    start    = 1'b1;
                    md_stall = 1'b1;
                    cnt_d    = 5'd0;
                    state_d  = CALC;
                end else if (ex_md_valid && ex_function_code == F_MTHI) begin
                    hi_d = ex_dato_1;
                end else if (ex_md_valid && ex_function_code == F_MTLO) begin
                    lo_d = ex_dato_1;
                end
            end
            CALC: begin
                md_stall = 1'b1;
                step     = 1'b1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                md_stall = 1'b1;
                hi_d     = res_hi;
                lo_d     = res_lo;
                state_d  = DONE;
            end
            default: state_d = IDLE;   // DONE: let the instruction leave EX
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    muldiv_datapath u_datapath (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .start_i    (start),
        .step_i     (step),
        .op_i       (op_sel),
        .a_i        (ex_dato_1),
        .b_i        (ex_dato_2),
        .res_hi_o   (res_hi),
        .res_lo_o   (res_lo),
        .div_zero_o (dp_div_zero)
    );

    always_comb begin
        md_mf_result = '0;
        if (ex_function_code == F_MFHI) begin
            md_mf_result = hi_q;
        end else if (ex_function_code == F_MFLO) begin
            md_mf_result = lo_q;
        end
    end

    assign md_hi          = hi_q;
    assign md_lo          = lo_q;
    assign md_div_by_zero = (state_q == FIX) && dp_div_zero;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit with a HI/LO result scoreboard.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        ex_md_valid;
    logic [5:0]  ex_function_code;
    logic [31:0] ex_dato_1, ex_dato_2;
    logic        md_stall;
    logic [31:0] md_mf_result, md_hi, md_lo;
    logic        md_div_by_zero;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .clk_en           (clk_en),
        .ex_md_valid      (ex_md_valid),
        .ex_function_code (ex_function_code),
        .ex_dato_1        (ex_dato_1),
        .ex_dato_2        (ex_dato_2),
        .md_stall         (md_stall),
        .md_mf_result     (md_mf_result),
        .md_hi            (md_hi),
        .md_lo            (md_lo),
        .md_div_by_zero   (md_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one mult/div op, hold it in EX while stalled, then score HI/LO at DONE.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_cyc,
                          input int exp_dbz, input int hold_at);
        int cyc = 0;
        int dbz = 0;
        logic [63:0] e;
        @(negedge clk);
        ex_md_valid = 1'b1; ex_function_code = f; ex_dato_1 = a; ex_dato_2 = b;
        sb_q.push_back(exp);
        #1;
        while (md_stall && cyc < 100) begin
            cyc++;
            if (md_div_by_zero) dbz++;
            if (hold_at != 0 && cyc == hold_at) clk_en = 1'b0;
            if (hold_at != 0 && cyc == hold_at + 5) clk_en = 1'b1;
            @(negedge clk); #1;
        end
        ex_md_valid = 1'b0;
        e = sb_q.pop_front();
        check({tag, "_hi"}, {32'd0, md_hi}, {32'd0, e[63:32]});
        check({tag, "_lo"}, {32'd0, md_lo}, {32'd0, e[31:0]});
        check({tag, "_stall_cycles"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_dbz_pulses"}, 64'(dbz), 64'(exp_dbz));
        $display("op %s a=%h b=%h hi=%h lo=%h stall=%0d dbz=%0d", tag, a, b, md_hi, md_lo, cyc, dbz);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1; ex_md_valid = 1'b0;
        ex_function_code = 6'h00; ex_dato_1 = '0; ex_dato_2 = '0;
        @(negedge clk); #1;
        check("rst_hi", {32'd0, md_hi}, 64'd0);
        check("rst_lo", {32'd0, md_lo}, 64'd0);
        check("rst_stall", {63'd0, md_stall}, 64'd0);
        check("rst_dbz", {63'd0, md_div_by_zero}, 64'd0);
        check("rst_mf", {32'd0, md_mf_result}, 64'd0);
        @(negedge clk); reset = 1'b0;

        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 34, 0, 0);
        run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 34, 0, 0);

        ex_md_valid = 1'b1; ex_function_code = F_MFLO; #1;
        check("mflo", {32'd0, md_mf_result}, 64'h0000_0000_FFFF_FFEB);
        check("mflo_stall", {63'd0, md_stall}, 64'd0);
        $display("mflo result=%h", md_mf_result);

        @(negedge clk);
        ex_function_code = F_MTHI; ex_dato_1 = 32'h1234_5678; #1;
        check("mthi_stall", {63'd0, md_stall}, 64'd0);
        @(negedge clk);
        ex_function_code = F_MFHI; #1;
        check("mfhi", {32'd0, md_mf_result}, 64'h0000_0000_1234_5678);
        check("mfhi_stall", {63'd0, md_stall}, 64'd0);
        $display("mthi/mfhi result=%h", md_mf_result);
        @(negedge clk);
        ex_function_code = F_MTLO; ex_dato_1 = 32'hCAFE_0001;
        @(negedge clk); ex_md_valid = 1'b0; #1;
        check("mtlo", {32'd0, md_lo}, 64'h0000_0000_CAFE_0001);
        $display("mtlo lo=%h", md_lo);

        run_op("mult_clken", F_MULT, 32'h1234_5678, 32'hFFFF_FFFE, 64'hFFFF_FFFF_DB97_5310, 39, 0, 10);

        // Abort a MULTU after ten CALC cycles; old LO must still be visible until then.
        @(negedge clk);
        ex_md_valid = 1'b1; ex_function_code = F_MULTU; ex_dato_1 = 32'd5; ex_dato_2 = 32'd6;
        sb_q.push_back(64'd0);
        repeat (11) @(negedge clk);
        #1;
        check("busy_old_lo", {32'd0, md_lo}, 64'h0000_0000_DB97_5310);
        check("busy_stall", {63'd0, md_stall}, 64'd1);
        reset = 1'b1; ex_md_valid = 1'b0; #1;
        begin
            logic [63:0] e;
            e = sb_q.pop_front();
            check("abort_hi", {32'd0, md_hi}, {32'd0, e[63:32]});
            check("abort_lo", {32'd0, md_lo}, {32'd0, e[31:0]});
        end
        check("abort_stall", {63'd0, md_stall}, 64'd0);
        $display("reset abort hi=%h lo=%h stall=%b", md_hi, md_lo, md_stall);
        @(negedge clk); reset = 1'b0;

`ifdef MULDIV_DIV_EN
        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0, 0);
        run_op("divu_zero", F_DIVU, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 34, 1, 0);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 34, 0, 0);
        run_op("divu_9_3", F_DIVU, 32'd9, 32'd3, 64'h0000_0000_0000_0003, 34, 0, 0);
        run_op("divu_rem", F_DIVU, 32'd1000, 32'd7, 64'h0000_0006_0000_008E, 34, 0, 0);
`else
        @(negedge clk);
        ex_md_valid = 1'b1; ex_function_code = F_MTHI; ex_dato_1 = 32'h0BAD_F00D;
        @(negedge clk);
        ex_function_code = F_DIVU; ex_dato_1 = 32'd9; ex_dato_2 = 32'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("divu_off_stall", {63'd0, md_stall}, 64'd0);
            @(negedge clk);
        end
        ex_md_valid = 1'b0; #1;
        check("divu_off_hi", {32'd0, md_hi}, 64'h0000_0000_0BAD_F00D);
        check("divu_off_lo", {32'd0, md_lo}, 64'd0);
        check("divu_off_dbz", {63'd0, md_div_by_zero}, 64'd0);
        $display("divu disabled hi=%h lo=%h", md_hi, md_lo);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
